// File: rtl/bus_dma_responder.sv
// Responder side of the bus/DMA request handshake: round-robin grant, one-cycle
// ack, fixed-length enable window, then a done pulse (or xfer_abort on abandon).
//
// state | meaning
// IDLE  | waiting for bus_req/dma_req; arbitrates on the next edge
// ACK   | ack to the owner is high for this single cycle
// XFER  | owner enable high; counter tracks cycles spent in the window
// DONE  | done pulse; requests are not sampled here
module bus_dma_responder #(
  parameter int XFER_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bus_req,
  input  logic dma_req,
  output logic bus_ack,
  output logic dma_ack,
  output logic bus_enb,
  output logic mem_enb,
  output logic done,
  output logic xfer_abort
);

  typedef enum logic [1:0] {IDLE, ACK, XFER, DONE} state_t;

  localparam logic [CNT_W-1:0] LEN = CNT_W'(XFER_LEN);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nx;
  // owner doubles as last_grant: it keeps the most recent grant after the transfer ends
  logic             owner, owner_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             owner_req;
  logic             bus_ack_nx, dma_ack_nx, bus_enb_nx, mem_enb_nx, done_nx, abort_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cnt        <= '0;
      bus_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      bus_enb    <= 1'b0;
      mem_enb    <= 1'b0;
      done       <= 1'b0;
      xfer_abort <= 1'b0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      cnt        <= cnt_nx;
      bus_ack    <= bus_ack_nx;
      dma_ack    <= dma_ack_nx;
      bus_enb    <= bus_enb_nx;
      mem_enb    <= mem_enb_nx;
      done       <= done_nx;
      xfer_abort <= abort_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    cnt_nx     = cnt;
    bus_ack_nx = 1'b0;
    dma_ack_nx = 1'b0;
    bus_enb_nx = 1'b0;
    mem_enb_nx = 1'b0;
    done_nx    = 1'b0;
    abort_nx   = 1'b0;
    owner_req  = owner ? dma_req : bus_req;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bus_req || dma_req) begin
          // owner 0 = BUS, 1 = DMA; a tie goes to whoever was not granted last
          if (bus_req && dma_req) owner_nx = ~owner;
          else                    owner_nx = dma_req;
          state_nx   = ACK;
          bus_ack_nx = ~owner_nx;
          dma_ack_nx = owner_nx;
        end
      end
      ACK: begin
        if (!owner_req) begin
          state_nx = IDLE;
          abort_nx = 1'b1;
          cnt_nx   = '0;
        end else begin
          state_nx   = XFER;
          cnt_nx     = ONE;
          bus_enb_nx = ~owner;
          mem_enb_nx = owner;
        end
      end
      XFER: begin
        // abandon wins even on the final enable cycle: the transfer is not complete yet
        if (!owner_req) begin
          state_nx = IDLE;
          abort_nx = 1'b1;
          cnt_nx   = '0;
        end else if (cnt >= LEN) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          cnt_nx     = cnt + ONE;
          bus_enb_nx = ~owner;
          mem_enb_nx = owner;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_dma_responder.sv
// Bench for bus_dma_responder: directed scenarios plus a long randomized run
// checked against a transaction-level schedule model.
module tb_bus_dma_responder;

  localparam int L = 4;
  localparam int NONE = 0, BACK = 1, DACK = 2, BENB = 3, MENB = 4, DN = 5, AB = 6;

  logic clk, rst_n;
  logic bus_req, dma_req;
  logic bus_ack, dma_ack, bus_enb, mem_enb, done, xfer_abort;
  logic bus_req1, dma_req1;
  logic bus_ack1, dma_ack1, bus_enb1, mem_enb1, done1, xfer_abort1;

  int checks = 0;
  int failures = 0;

  bus_dma_responder #(.XFER_LEN(L), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .dma_req(dma_req),
    .bus_ack(bus_ack), .dma_ack(dma_ack), .bus_enb(bus_enb), .mem_enb(mem_enb),
    .done(done), .xfer_abort(xfer_abort)
  );

  bus_dma_responder #(.XFER_LEN(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req1), .dma_req(dma_req1),
    .bus_ack(bus_ack1), .dma_ack(dma_ack1), .bus_enb(bus_enb1), .mem_enb(mem_enb1),
    .done(done1), .xfer_abort(xfer_abort1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector to a single code; -1 flags more than one output high, -2 flags X/Z.
  function automatic int code_of(input logic a, input logic b, input logic c,
                                 input logic d, input logic e, input logic f);
    if ($isunknown({a, b, c, d, e, f})) return -2;
    if ($countones({a, b, c, d, e, f}) > 1) return -1;
    if (a) return BACK;
    if (b) return DACK;
    if (c) return BENB;
    if (d) return MENB;
    if (e) return DN;
    if (f) return AB;
    return NONE;
  endfunction

  function automatic int obs();
    return code_of(bus_ack, dma_ack, bus_enb, mem_enb, done, xfer_abort);
  endfunction

  function automatic int obs1();
    return code_of(bus_ack1, dma_ack1, bus_enb1, mem_enb1, done1, xfer_abort1);
  endfunction

  // Reference model: the output of the current cycle plus a queue of the
  // outputs already promised for the coming cycles of an accepted grant.
  int cur;
  int plan[$];
  bit last_dma;

  task automatic model_reset();
    cur = NONE;
    plan.delete();
    last_dma = 1'b0;
  endtask

  task automatic model_edge(input logic b, input logic d);
    logic oreq;
    oreq = last_dma ? d : b;
    if ((cur == BACK || cur == DACK || cur == BENB || cur == MENB) && !oreq) begin
      cur = AB;
      plan.delete();
    end else if (plan.size() > 0) begin
      cur = plan.pop_front();
    end else if (b || d) begin
      last_dma = (b && d) ? !last_dma : d;
      cur = last_dma ? DACK : BACK;
      for (int i = 0; i < L; i++) plan.push_back(last_dma ? MENB : BENB);
      plan.push_back(DN);
      plan.push_back(NONE);
    end else begin
      cur = NONE;
    end
  endtask

  task automatic step();
    logic b, d;
    b = bus_req;
    d = dma_req;
    @(posedge clk);
    #1;
    model_edge(b, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_req = 0; dma_req = 0; bus_req1 = 0; dma_req1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== NONE) begin
      failures++;
      $display("FAIL reset_outputs got=%0d exp=%0d", obs(), NONE);
    end
    checks++;
    if (obs1() !== NONE) begin
      failures++;
      $display("FAIL reset_outputs_len1 got=%0d exp=%0d", obs1(), NONE);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_bus();
    int exp_seq[7] = '{BACK, BENB, BENB, BENB, BENB, DN, NONE};
    bus_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 5) bus_req = 1'b0;
      checks++;
      if (obs() !== exp_seq[i]) begin
        failures++;
        $display("FAIL single_bus cyc=%0d got=%0d exp=%0d", i, obs(), exp_seq[i]);
      end
    end
  endtask

  task automatic test_tie();
    int ack_cyc[$];
    int ack_code[$];
    int exp_code[4] = '{DACK, BACK, DACK, BACK};
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_req = 1'b1;
    dma_req = 1'b1;
    for (int i = 0; i < 28; i++) begin
      step();
      if (i == 26) begin
        bus_req = 1'b0;
        dma_req = 1'b0;
      end
      if (obs() == BACK || obs() == DACK) begin
        ack_cyc.push_back(i);
        ack_code.push_back(obs());
      end
      checks++;
      if (obs() !== cur) begin
        failures++;
        $display("FAIL tie_model cyc=%0d got=%0d exp=%0d", i, obs(), cur);
      end
    end
    checks++;
    if (ack_cyc.size() != 4) begin
      failures++;
      $display("FAIL tie_ack_count got=%0d exp=4", ack_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ack_code[k] != exp_code[k] || ack_cyc[k] != 7 * k) begin
          failures++;
          $display("FAIL tie_grant k=%0d got=%0d@%0d exp=%0d@%0d",
                   k, ack_code[k], ack_cyc[k], exp_code[k], 7 * k);
        end
      end
    end
  endtask

  task automatic test_abandon();
    int exp_seq[5] = '{DACK, MENB, MENB, AB, NONE};
    dma_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 2) dma_req = 1'b0;
      checks++;
      if (obs() !== exp_seq[i]) begin
        failures++;
        $display("FAIL abandon cyc=%0d got=%0d exp=%0d", i, obs(), exp_seq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    bus_req = 1'b1;
    repeat (3) step();
    checks++;
    if (obs() !== BENB) begin
      failures++;
      $display("FAIL async_pre got=%0d exp=%0d", obs(), BENB);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== NONE) begin
      failures++;
      $display("FAIL async_reset_outputs got=%0d exp=%0d", obs(), NONE);
    end
    model_reset();
    @(posedge clk);
    #1;
    bus_req = 1'b1;
    dma_req = 1'b1;
    rst_n = 1'b1;
    step();
    checks++;
    if (obs() !== DACK) begin
      failures++;
      $display("FAIL async_first_grant got=%0d exp=%0d", obs(), DACK);
    end
    bus_req = 1'b0;
    dma_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== cur) begin
        failures++;
        $display("FAIL async_recover cyc=%0d got=%0d exp=%0d", i, obs(), cur);
      end
    end
  endtask

  task automatic test_len1();
    int exp_seq[5] = '{BACK, BENB, DN, NONE, NONE};
    bus_req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 2) bus_req1 = 1'b0;
      checks++;
      if (obs1() !== exp_seq[i]) begin
        failures++;
        $display("FAIL len1 cyc=%0d got=%0d exp=%0d", i, obs1(), exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) bus_req = ~bus_req;
      if ($urandom_range(7) == 0) dma_req = ~dma_req;
      step();
      checks++;
      if (obs() !== cur) begin
        failures++;
        $display("FAIL random cyc=%0d got=%0d exp=%0d", i, obs(), cur);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bus();
    test_tie();
    test_abandon();
    test_async_reset();
    test_len1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
